// File: rtl/gcd_engine_param.sv
// rtl/gcd_engine_param.sv - parametrised GCD engine (subtraction or binary Stein), handshaked in/out
// Optional cycle counter output enabled by `GCD_CYCLE_COUNT_EN.
module gcd_engine_param #(
    parameter int WIDTH = 16,
    parameter int ALGO  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
`ifdef GCD_CYCLE_COUNT_EN
    output logic [31:0]      cycle_count,
`endif
    output logic             busy
);
    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_STRIP, S_REDUCE, S_FINISH, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             zero_flag_q, zero_flag_d;
    logic             accept;
    logic [WIDTH-1:0] diff_ab, diff_ba;

    assign diff_ab   = a_q - b_q;
    assign diff_ba   = b_q - a_q;
    assign accept    = (state_q == S_IDLE) && in_valid;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_STRIP) || (state_q == S_REDUCE) || (state_q == S_FINISH);
    assign result    = result_q;
    assign zero_flag = zero_flag_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        result_d    = result_q;
        zero_flag_d = zero_flag_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a_in;
                    b_d = b_in;
                    k_d = '0;
                    if ((a_in == '0) || (b_in == '0)) begin
                        result_d    = a_in | b_in;
                        zero_flag_d = ((a_in | b_in) == '0);
                        state_d     = S_DONE;
                    end else begin
                        state_d = (ALGO == 1) ? S_STRIP : S_REDUCE;
                    end
                end
            end
            S_STRIP: begin
                // Shared factors of two are removed here and restored in FINISH
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (ALGO == 1) begin
                    if (!a_q[0])           a_d = a_q >> 1;
                    else if (!b_q[0])      b_d = b_q >> 1;
                    else if (a_q == b_q)   state_d = S_FINISH;
                    else if (a_q > b_q)    a_d = diff_ab >> 1;
                    else                   b_d = diff_ba >> 1;
                end else begin
                    if (a_q == b_q)        state_d = S_FINISH;
                    else if (a_q > b_q)    a_d = diff_ab;
                    else                   b_d = diff_ba;
                end
            end
            S_FINISH: begin
                result_d    = a_q << k_q;
                zero_flag_d = 1'b0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            result_q    <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            result_q    <= result_d;
            zero_flag_q <= zero_flag_d;
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (accept)
            cycle_count_d = '0;
        else if (busy && (cycle_count_q != '1))
            cycle_count_d = cycle_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cycle_count_q <= '0;
        else        cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`endif
endmodule

// File: doc/gcd_engine_param.md
Name: gcd_engine_param

Overview:
- Parametrised GCD engine; successor to the fixed 16-bit subtract-only GCD datapath/controller pair.
- Operands load in parallel through a valid/ready handshake; result is returned with a held valid/ready handshake.
- Width and algorithm are selectable: repeated subtraction, or binary (Stein) with shared-power-of-two stripping.
- Handles zero operands explicitly and sits as a reusable arithmetic slave behind a host controller.

Parameters:
- WIDTH, 16, operand and result width in bits (min 2).
- ALGO, 1, 0 = subtraction Euclid, 1 = binary Stein.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  engine can accept operands.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- out_valid  out  1  result available, held until taken.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  GCD(A,B).
- zero_flag  out  1  both operands were 0; valid with out_valid.
- busy  out  1  high in STRIP/REDUCE/FINISH.

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, zero_flag=0, busy=0, internal a/b/k cleared. Reset mid-operation abandons the computation; no result is produced.
- Internal regs: a, b (WIDTH); shift count k (clog2(WIDTH+1) bits). All arithmetic is unsigned. Subtraction occurs only as larger-minus-smaller, so there is no underflow.
- IDLE: in_ready=1. Accept on in_valid & in_ready: latch a=a_in, b=b_in, k=0.
  - If a_in==0 or b_in==0: result=a_in|b_in, zero_flag=(both 0), go to DONE.
  - Else go to STRIP (ALGO=1) or REDUCE (ALGO=0).
- STRIP (ALGO=1 only), one decision per cycle:
  - Both a and b even: a>>=1, b>>=1, k++, stay in STRIP.
  - Otherwise: go to REDUCE with no register change.
- REDUCE, ALGO=1, priority order, one step per cycle:
  1. a even: a>>=1.
  2. Else b even: b>>=1.
  3. Else a==b: go to FINISH.
  4. Else a>b: a=(a-b)>>1.
  5. Else b=(b-a)>>1.
- REDUCE, ALGO=0, one step per cycle:
  - a==b: go to FINISH.
  - a>b: a=a-b.
  - Else b=b-a.
- FINISH (1 cycle): result=a<<k, zero_flag=0, go to DONE.
- DONE: out_valid=1; result and zero_flag held stable.
  - On out_ready: out_valid=0 on the next edge, go to IDLE.
  - in_ready=0 throughout DONE. There is no pass-through; a new accept can occur no earlier than the cycle after the result is taken.
- in_ready is low in every state except IDLE. in_valid outside IDLE is ignored and a_in/b_in are not sampled.
- Latency, accept edge to out_valid edge:
  - Zero operand: 1 cycle.
  - Otherwise: (cycles in STRIP+REDUCE+FINISH) + 1.
- Worst case, ALGO=0: about 2^WIDTH cycles (e.g. 1, 2^WIDTH-1).
- Worst case, ALGO=1: at most 2*WIDTH+2 cycles.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycle_count (out, 32 bits).
  - Counts cycles spent in STRIP, REDUCE and FINISH for the current operation.
  - Cleared on accept; held stable while out_valid=1; reset value 0.
  - Saturates at 2^32-1.
  - Zero-operand case reports 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALGO=1, WIDTH=16: a=48, b=18 -> result=6, zero_flag=0; with GCD_CYCLE_COUNT_EN, cycle_count=8 (STRIP 2, REDUCE 5, FINISH 1).
- ALGO=0, WIDTH=16: a=90, b=81 -> result=9; cycle_count=11.
- Zero operands: (0,35) -> result=35, zero_flag=0. (0,0) -> result=0, zero_flag=1. Both: out_valid one cycle after accept, cycle_count=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, next operand pair accepted.
- Reset mid-op: ALGO=0, (65535,1), assert rst_n=0 at cycle 20 -> next edge shows out_valid=0, in_ready=1, result=0. A subsequent (12,8) returns 4.
- Width/boundary: WIDTH=8, ALGO=1: (255,255) -> 255; (128,64) -> 64; (1,200) -> 1. Randomised 1000 pairs per ALGO against a reference model.
